// File: rtl/matrix_mult_stream_ctrl.sv
// matrix_mult_stream_ctrl: streams A/B operands into the 8x8 matmul engine and streams its 64 results back out
module matrix_mult_stream_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic          HCLK,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [31:0]   m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          mm_start,
    output logic [1:0]    mm_reuse,
    output logic [511:0]  mm_a,
    output logic [511:0]  mm_b,
    input  logic [1023:0] mm_result,
    input  logic          mm_done,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, DRAIN} state_t;
    state_t          state;
    logic [4:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic [1023:0]   cap;
    assign s_ready  = state == LOAD_A || state == LOAD_B;
    assign m_valid  = state == DRAIN;
    assign m_last   = m_valid && cnt == 5'd31;
    assign m_data   = cap[{cnt, 5'b0} +: 32];
    assign mm_start = state == START;
    assign mm_reuse = 2'b00;
    assign busy     = !(state == LOAD_A && cnt == 5'd0);
    always_ff @(posedge HCLK) begin
        if (reset) begin
            state      <= LOAD_A;
            cnt        <= '0;
            tcnt       <= '0;
            mm_a       <= '0;
            mm_b       <= '0;
            cap        <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD_A: if (s_valid) begin
                    mm_a[{cnt[3:0], 5'b0} +: 32] <= s_data;
                    cnt   <= cnt == 5'd15 ? 5'd0 : cnt + 5'd1;
                    state <= cnt == 5'd15 ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (s_valid) begin
                    mm_b[{cnt[3:0], 5'b0} +: 32] <= s_data;
                    cnt   <= cnt == 5'd15 ? 5'd0 : cnt + 5'd1;
                    state <= cnt == 5'd15 ? START : LOAD_B;
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                // done on the final timeout edge still wins over the abort
                WAIT: if (mm_done) begin
                    cap   <= mm_result;
                    state <= DRAIN;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    state <= LOAD_A;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                DRAIN: if (m_ready) begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state      <= LOAD_A;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_stream_ctrl.sv
// tb_matrix_mult_stream_ctrl: directed frames against a behavioural engine model
module tb_matrix_mult_stream_ctrl;
    logic          HCLK = 0, reset = 1, s_valid = 0, m_ready = 0;
    logic [31:0]   s_data = 0;
    logic          s_ready, m_valid, m_last, mm_start, mm_done, busy, frame_done, err;
    logic [31:0]   m_data;
    logic [1:0]    mm_reuse;
    logic [511:0]  mm_a, mm_b;
    logic [1023:0] mm_result;
    logic [1023:0] res = 0;
    logic          eng_done = 0;
    int            eng_cnt = 0;
    bit            eng_en = 1, stray = 0;
    int            total = 0, bad = 0, starts = 0;
    matrix_mult_stream_ctrl #(.TIMEOUT(64)) dut (
        .HCLK(HCLK), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .mm_start(mm_start), .mm_reuse(mm_reuse), .mm_a(mm_a), .mm_b(mm_b),
        .mm_result(mm_result), .mm_done(mm_done), .busy(busy), .frame_done(frame_done), .err(err)
    );
    always #5 HCLK = ~HCLK;
    assign mm_done   = eng_done | stray;
    assign mm_result = stray ? ~res : res;
    function automatic logic [1023:0] mmul(input logic [511:0] a, input logic [511:0] b);
        logic [15:0] s;
        mmul = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += 16'(a[8*(i*8+k) +: 8]) * 16'(b[8*(k*8+j) +: 8]);
                mmul[16*(i*8+j) +: 16] = s;
            end
    endfunction
    always @(posedge HCLK) begin
        eng_done <= 0;
        if (mm_start && !reset) starts <= starts + 1;
        if (reset) eng_cnt <= 0;
        else if (mm_start) begin
            res     <= mmul(mm_a, mm_b);
            eng_cnt <= eng_en ? 11 : 0;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done <= 1;
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask
    task automatic send_mat(input logic [511:0] m, input int gap, input int nw = 16);
        for (int k = 0; k < nw; k++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) tick;
            s_valid = 1;
            s_data  = m[32*k +: 32];
            tick;
            s_valid = 0;
        end
    endtask
    task automatic recv(input logic [1023:0] exp, input int stall, input int stray_at = -1, input int stop_at = -1);
        int n;
        logic [31:0] hold;
        n = 0;
        m_ready = 0;
        while (!m_valid && n < 200) begin
            tick;
            n++;
        end
        chk("m_valid_wait", 64'(m_valid), 1);
        if (!m_valid) return;
        for (int m = 0; m < 32; m++) begin
            if (m == stop_at) return;
            hold = m_data;
            if (stall > 0) repeat ($urandom_range(0, stall)) begin
                tick;
                chk("stall_data", m_data, hold);
            end
            if (m == stray_at) begin
                stray = 1;
                tick;
                stray = 0;
            end
            chk($sformatf("m_data[%0d]", m), m_data, exp[32*m +: 32]);
            chk($sformatf("m_last[%0d]", m), 64'(m_last), 64'(m == 31));
            m_ready = 1;
            tick;
            m_ready = 0;
        end
        chk("frame_done", 64'(frame_done), 1);
        tick;
        chk("frame_done_pulse", 64'(frame_done), 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
    initial begin
        logic [511:0]  id, bj, ff, ra, rb;
        logic [1023:0] exp_id, exp_ff, exp_r;
        int s0, n;
        bit mv;
        for (int j = 0; j < 64; j++) begin
            id[8*j +: 8] = (j / 8 == j % 8) ? 8'd1 : 8'd0;
            bj[8*j +: 8] = 8'(j);
        end
        for (int m = 0; m < 32; m++) exp_id[32*m +: 32] = {16'(2*m+1), 16'(2*m)};
        ff     = {64{8'hFF}};
        exp_ff = {32{32'hF008_F008}};
        repeat (3) tick;
        chk("rst_s_ready", 64'(s_ready), 1);
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_m_last", 64'(m_last), 0);
        chk("rst_mm_start", 64'(mm_start), 0);
        chk("rst_mm_reuse", 64'(mm_reuse), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_frame_done", 64'(frame_done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_mm_a", 64'(mm_a == 0 && mm_b == 0), 1);
        reset = 0;
        tick;
        stray = 1;
        tick;
        stray = 0;
        chk("idle_stray_busy", 64'(busy), 0);
        chk("idle_stray_m_valid", 64'(m_valid), 0);
        // identity x ramp, no stalls, stray done mid-drain
        s0 = starts;
        send_mat(id, 0);
        chk("a_loaded_busy", 64'(busy), 1);
        send_mat(bj, 0);
        chk("start_s_ready", 64'(s_ready), 0);
        chk("start_pulse", 64'(mm_start), 1);
        chk("start_a_held", 64'(mm_a == id && mm_b == bj), 1);
        tick;
        chk("start_once", 64'(mm_start), 0);
        recv(exp_id, 0, 5);
        chk("id_starts", 64'(starts - s0), 1);
        send_mat(ff, 0);
        send_mat(ff, 0);
        recv(exp_ff, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                ra[32*i +: 32] = $urandom;
                rb[32*i +: 32] = $urandom;
            end
            exp_r = mmul(ra, rb);
            s0 = starts;
            send_mat(ra, 2);
            send_mat(rb, 2);
            recv(exp_r, 2);
            chk("rand_starts", 64'(starts - s0), 1);
        end
        // engine never finishes: abort after 64 WAIT cycles
        eng_en = 0;
        send_mat(id, 0);
        send_mat(bj, 0);
        n  = 0;
        mv = 0;
        while (!err && n < 200) begin
            tick;
            n++;
            mv |= m_valid;
        end
        chk("timeout_cycles", 64'(n), 65);
        chk("timeout_no_m_valid", 64'(mv), 0);
        chk("timeout_s_ready", 64'(s_ready), 1);
        chk("timeout_busy", 64'(busy), 0);
        eng_en = 1;
        send_mat(id, 0);
        send_mat(bj, 0);
        recv(exp_id, 1);
        chk("err_sticky", 64'(err), 1);
        // reset in LOAD_B after word 7
        send_mat(ff, 0);
        send_mat(bj, 0, 8);
        reset = 1;
        tick;
        chk("rstb_s_ready", 64'(s_ready), 1);
        chk("rstb_busy", 64'(busy), 0);
        chk("rstb_err", 64'(err), 0);
        chk("rstb_operands", 64'(mm_a == 0 && mm_b == 0), 1);
        reset = 0;
        s0 = starts;
        repeat (15) tick;
        chk("rstb_no_start", 64'(starts - s0), 0);
        // reset in DRAIN at word 10
        send_mat(id, 0);
        send_mat(bj, 0);
        recv(exp_id, 0, -1, 10);
        reset = 1;
        tick;
        chk("rstd_m_valid", 64'(m_valid), 0);
        chk("rstd_m_last", 64'(m_last), 0);
        chk("rstd_s_ready", 64'(s_ready), 1);
        chk("rstd_busy", 64'(busy), 0);
        reset = 0;
        tick;
        send_mat(ff, 1);
        send_mat(ff, 1);
        recv(exp_ff, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
